key_debounce: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 23 ++
 rtl/key_debounce_ch.sv | 162 ++++++++++++++++
 rtl/key_debounce.sv | 71 +++++++
 tb/tb_key_debounce.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and elaboration helpers for the key debounce block.
package key_debounce_pkg;

    // Per-channel debounce state.
    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } key_state_t;

    // Number of clock cycles spanning the given number of milliseconds.
    function automatic int unsigned f_ms2cycles(input int unsigned clk_hz,
                                                input int unsigned ms);
        return (clk_hz / 32'd1000) * ms;
    endfunction

    // Counter width able to hold every value from 0 up to and including cycles.
    function automatic int unsigned f_cntw(input int unsigned cycles);
        return $clog2(cycles + 32'd1);
    endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// One key channel: 2-flop synchroniser, debounce FSM with a shared
// stable/hold counter, and registered level, press, release and long pulses.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEB_CYCLES  = 32'd10,
    parameter int unsigned LONG_CYCLES = 32'd50,
    parameter int unsigned CNT_W       = 32'd6,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic i_clk_25m,
    input  logic i_rst,
    input  logic i_key,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long,
    output logic o_press_nxt
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(32'd1);
    localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 32'd1);
    localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);
    // Raw pin value of a released key; the synchroniser resets to it so a
    // reset never looks like an edge.
    localparam logic             KEY_IDLE  = ACTIVE_LOW;

    logic [1:0]       sync_q;
    logic [1:0]       sync_d;
    logic             key_p_s;
    key_state_t       state_q;
    key_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             level_q;
    logic             level_d;
    logic             press_q;
    logic             press_d;
    logic             release_q;
    logic             release_d;
    logic             long_q;
    logic             long_d;

    // Shift the raw pin into the synchroniser and normalise it to 1 = pressed.
    always_comb begin
        sync_d = {sync_q[0], i_key};
        if (ACTIVE_LOW) begin
            key_p_s = ~sync_q[1];
        end else begin
            key_p_s = sync_q[1];
        end
    end

    // Next state, counter and pulse requests; the counter measures stability
    // in the WAIT states and hold time in DOWN.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        case (state_q)
            UP: begin
                cnt_d = CNT_ZERO;
                if (key_p_s) begin
                    state_d = WAIT_DOWN;
                end else begin
                    state_d = UP;
                end
            end
            WAIT_DOWN: begin
                if (key_p_s) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d = DOWN;
                        cnt_d   = CNT_ZERO;
                        press_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    state_d = UP;
                    cnt_d   = CNT_ZERO;
                end
            end
            DOWN: begin
                if (key_p_s) begin
                    // Saturate after the long pulse so it fires once per hold.
                    if (cnt_q == LONG_LAST) begin
                        long_d = 1'b1;
                        cnt_d  = LONG_SAT;
                    end else if (cnt_q < LONG_LAST) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end else begin
                    state_d = WAIT_UP;
                    cnt_d   = CNT_ZERO;
                end
            end
            WAIT_UP: begin
                if (!key_p_s) begin
                    if (cnt_q == DEB_LAST) begin
                        state_d   = UP;
                        cnt_d     = CNT_ZERO;
                        release_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end else begin
                    // Release bounce: back to DOWN, the long-press timer restarts.
                    state_d = DOWN;
                    cnt_d   = CNT_ZERO;
                end
            end
            default: begin
                state_d = UP;
                cnt_d   = CNT_ZERO;
            end
        endcase
    end

    // Debounced level follows the state being entered so it moves with the pulses.
    always_comb begin
        if ((state_d == DOWN) || (state_d == WAIT_UP)) begin
            level_d = 1'b1;
        end else begin
            level_d = 1'b0;
        end
    end

    // Synchroniser, FSM, counter and output registers with synchronous reset.
    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            sync_q    <= {2{KEY_IDLE}};
            state_q   <= UP;
            cnt_q     <= CNT_ZERO;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
        end
    end

    assign o_level     = level_q;
    assign o_press     = press_q;
    assign o_release   = release_q;
    assign o_long      = long_q;
    // Unregistered press request, used by the top to register the any-press OR.
    assign o_press_nxt = press_d;

endmodule

// File: rtl/key_debounce.sv
// Multi-key debounce front end: one independent channel per key plus a
// registered any-press flag aligned with the per-key press pulses.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int unsigned NUM_KEYS    = 32'd4,
    parameter int unsigned CLK_HZ      = 32'd25_000_000,
    parameter int unsigned DEBOUNCE_MS = 32'd20,
    parameter int unsigned LONG_MS     = 32'd1000,
    parameter bit          ACTIVE_LOW  = 1'b1
) (
    input  logic                i_clk_25m,
    input  logic                i_rst,
    input  logic [NUM_KEYS-1:0] i_key,
    output logic [NUM_KEYS-1:0] o_key_level,
    output logic [NUM_KEYS-1:0] o_key_press,
    output logic [NUM_KEYS-1:0] o_key_release,
    output logic [NUM_KEYS-1:0] o_key_long,
    output logic                o_any_press
);

    localparam int unsigned DEB_CYCLES  = f_ms2cycles(CLK_HZ, DEBOUNCE_MS);
    localparam int unsigned LONG_CYCLES = f_ms2cycles(CLK_HZ, LONG_MS);
    localparam int unsigned MAX_CYCLES  = (DEB_CYCLES > LONG_CYCLES) ? DEB_CYCLES : LONG_CYCLES;
    localparam int unsigned CNT_W       = f_cntw(MAX_CYCLES);

    // The FSM needs at least two debounce cycles, and the long pulse must
    // come strictly after the press pulse.
    if ((DEB_CYCLES < 32'd2) || (LONG_CYCLES <= DEB_CYCLES)) begin : g_bad_params
        $error("key_debounce: need DEB_CYCLES >= 2 and LONG_CYCLES > DEB_CYCLES");
    end

    logic [NUM_KEYS-1:0] press_nxt_s;
    logic                any_press_q;
    logic                any_press_d;

    for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_ch
        key_debounce_ch #(
            .DEB_CYCLES  (DEB_CYCLES),
            .LONG_CYCLES (LONG_CYCLES),
            .CNT_W       (CNT_W),
            .ACTIVE_LOW  (ACTIVE_LOW)
        ) u_ch (
            .i_clk_25m   (i_clk_25m),
            .i_rst       (i_rst),
            .i_key       (i_key[gi]),
            .o_level     (o_key_level[gi]),
            .o_press     (o_key_press[gi]),
            .o_release   (o_key_release[gi]),
            .o_long      (o_key_long[gi]),
            .o_press_nxt (press_nxt_s[gi])
        );
    end

    // OR of next-cycle press requests so the registered flag matches o_key_press.
    always_comb begin
        any_press_d = |press_nxt_s;
    end

    // Any-press output register.
    always_ff @(posedge i_clk_25m) begin
        if (i_rst) begin
            any_press_q <= 1'b0;
        end else begin
            any_press_q <= any_press_d;
        end
    end

    assign o_any_press = any_press_q;

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: directed timeline checked against a table of
// expected outputs, then random bouncing keys checked every cycle against a
// run-length reference model. Two DUTs: 4 active-low keys and 1 active-high key.
module tb_key_debounce;

    localparam int DEB  = 10;   // 10 kHz * 1 ms
    localparam int LONG = 50;   // 10 kHz * 5 ms
    localparam int DIR_END = 800;
    localparam int TOTAL   = 4800;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key_a;
    logic [0:0] key_b;
    logic [3:0] lvl_a, prs_a, rel_a, lng_a;
    logic       any_a;
    logic [0:0] lvl_b, prs_b, rel_b, lng_b;
    logic       any_b;

    always #5 clk = ~clk;

    key_debounce #(
        .NUM_KEYS(4), .CLK_HZ(10_000), .DEBOUNCE_MS(1), .LONG_MS(5), .ACTIVE_LOW(1'b1)
    ) dut_a (
        .i_clk_25m(clk), .i_rst(rst), .i_key(key_a),
        .o_key_level(lvl_a), .o_key_press(prs_a), .o_key_release(rel_a),
        .o_key_long(lng_a), .o_any_press(any_a)
    );

    key_debounce #(
        .NUM_KEYS(1), .CLK_HZ(10_000), .DEBOUNCE_MS(1), .LONG_MS(5), .ACTIVE_LOW(1'b0)
    ) dut_b (
        .i_clk_25m(clk), .i_rst(rst), .i_key(key_b),
        .o_key_level(lvl_b), .o_key_press(prs_b), .o_key_release(rel_b),
        .o_key_long(lng_b), .o_any_press(any_b)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    task automatic chk(input string name, input logic [4:0] act, input logic [4:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model (channels 0..3 = dut_a, 4 = dut_b) ----
    // Two-cycle input delay, then: the accepted level flips once the
    // synchronised pressed value has disagreed with it on DEB+1 consecutive
    // edges; hold counts agreeing pressed edges since the level was (re)established.
    logic [4:0] m_d1, m_d2, m_lvl, m_prs, m_rel, m_lng;
    logic       m_any;
    int         m_run[5];
    int         m_hold[5];

    task automatic model_step(input logic [4:0] raw, input logic r);
        for (int ch = 0; ch < 5; ch++) begin
            logic idle;
            logic p;
            idle = (ch < 4) ? 1'b1 : 1'b0;
            m_prs[ch] = 1'b0;
            m_rel[ch] = 1'b0;
            m_lng[ch] = 1'b0;
            if (r) begin
                m_d1[ch] = idle;
                m_d2[ch] = idle;
                m_lvl[ch] = 1'b0;
                m_run[ch] = 0;
                m_hold[ch] = 0;
            end else begin
                p = m_d2[ch] ^ idle;
                m_d2[ch] = m_d1[ch];
                m_d1[ch] = raw[ch];
                if (p != m_lvl[ch]) begin
                    m_run[ch]++;
                    if (m_run[ch] == DEB + 1) begin
                        m_lvl[ch] = p;
                        m_run[ch] = 0;
                        m_hold[ch] = 0;
                        if (p) m_prs[ch] = 1'b1;
                        else   m_rel[ch] = 1'b1;
                    end
                end else begin
                    if (m_lvl[ch]) begin
                        if (m_run[ch] > 0) begin
                            m_hold[ch] = 0;
                        end else if (m_hold[ch] < LONG) begin
                            m_hold[ch]++;
                            if (m_hold[ch] == LONG) m_lng[ch] = 1'b1;
                        end
                    end
                    m_run[ch] = 0;
                end
            end
        end
        m_any = |m_prs[3:0];
    endtask

    // ---------------- directed tables ---------------------------------------
    typedef struct {
        int         cyc;
        logic [3:0] ka;
        logic       kb;
        logic       r;
    } drive_t;

    typedef struct {
        int         cyc;
        logic [3:0] lvl, prs, rel, lng;
        logic       any;
        logic       b_lvl, b_prs, b_lng;
    } check_t;

    drive_t drv_q[$];
    check_t chk_q[$];

    task automatic add_drv(input int c, input logic [3:0] ka, input logic kb, input logic r);
        drive_t d;
        d.cyc = c; d.ka = ka; d.kb = kb; d.r = r;
        drv_q.push_back(d);
    endtask

    task automatic add_chk(input int c, input logic [3:0] l, input logic [3:0] p,
                           input logic [3:0] rl, input logic [3:0] g, input logic a,
                           input logic bl, input logic bp, input logic bg);
        check_t k;
        k.cyc = c; k.lvl = l; k.prs = p; k.rel = rl; k.lng = g; k.any = a;
        k.b_lvl = bl; k.b_prs = bp; k.b_lng = bg;
        chk_q.push_back(k);
    endtask

    int rem[5];

    function automatic int pick_len();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 6)      return $urandom_range(1, 14);
        else if (sel < 9) return $urandom_range(15, 40);
        else              return $urandom_range(55, 90);
    endfunction

    initial begin
        int di;
        int ci;
        rst   = 1'b1;
        key_a = 4'b1111;
        key_b = 1'b0;
        di = 0;
        ci = 0;

        // stimulus timeline: {cycle, key_a, key_b, rst}
        add_drv(5,   4'b1111, 1'b0, 1'b0);   // leave reset
        add_drv(100, 4'b1110, 1'b1, 1'b0);   // clean press key0, dut_b key
        add_drv(120, 4'b1100, 1'b1, 1'b0);   // key1 bounce: low 6
        add_drv(126, 4'b1110, 1'b1, 1'b0);   //   high 3
        add_drv(129, 4'b1100, 1'b1, 1'b0);   //   low 9
        add_drv(138, 4'b1110, 1'b1, 1'b0);   //   high
        add_drv(150, 4'b1100, 1'b1, 1'b0);   // key1 held
        add_drv(300, 4'b1101, 1'b1, 1'b0);   // release key0
        add_drv(330, 4'b1100, 1'b1, 1'b0);   // press key0 again
        add_drv(360, 4'b1101, 1'b1, 1'b0);   // 5-cycle release glitch on key0
        add_drv(365, 4'b1100, 1'b1, 1'b0);
        add_drv(450, 4'b1110, 1'b1, 1'b0);   // release key1
        add_drv(500, 4'b0010, 1'b1, 1'b0);   // key2+key3 together
        add_drv(550, 4'b0011, 1'b1, 1'b0);   // release key0
        add_drv(600, 4'b0010, 1'b1, 1'b0);   // press key0
        add_drv(643, 4'b0010, 1'b1, 1'b1);   // reset while key0 cnt=30
        add_drv(644, 4'b0010, 1'b1, 1'b0);
        add_drv(750, 4'b1111, 1'b0, 1'b0);   // release everything

        // expected outputs: {cycle, lvl, prs, rel, lng, any, b_lvl, b_prs, b_lng}
        add_chk(3,   4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        add_chk(112, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        add_chk(113, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        add_chk(114, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(140, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(162, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(163, 4'b0011, 4'b0010, 4'b0000, 4'b0001, 1'b1, 1'b1, 1'b0, 1'b1);
        add_chk(164, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(213, 4'b0011, 4'b0000, 4'b0000, 4'b0010, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(250, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(312, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(313, 4'b0010, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(343, 4'b0011, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        add_chk(370, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(393, 4'b0011, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(418, 4'b0011, 4'b0000, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(463, 4'b0001, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(513, 4'b1101, 4'b1100, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        add_chk(514, 4'b1101, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(563, 4'b1100, 4'b0000, 4'b0001, 4'b1100, 1'b0, 1'b1, 1'b0, 1'b0);
        add_chk(613, 4'b1101, 4'b0001, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0);
        add_chk(644, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        add_chk(656, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);
        add_chk(657, 4'b1101, 4'b1101, 4'b0000, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0);
        add_chk(707, 4'b1101, 4'b0000, 4'b0000, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b1);
        add_chk(763, 4'b0000, 4'b0000, 4'b1101, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0);

        for (int k = 0; k < 5; k++) begin
            m_run[k]  = 0;
            m_hold[k] = 0;
            rem[k]    = 1;
        end
        m_d1 = 5'b01111; m_d2 = 5'b01111;
        m_lvl = 5'b0; m_prs = 5'b0; m_rel = 5'b0; m_lng = 5'b0; m_any = 1'b0;

        for (int step = 1; step <= TOTAL; step++) begin
            @(posedge clk);
            cyc = step;
            model_step({key_b, key_a}, rst);
            #1;
            // model comparison every cycle
            chk("model_level",   {lvl_b, lvl_a}, m_lvl);
            chk("model_press",   {prs_b, prs_a}, m_prs);
            chk("model_release", {rel_b, rel_a}, m_rel);
            chk("model_long",    {lng_b, lng_a}, m_lng);
            chk("model_any",     {4'b0000, any_a}, {4'b0000, m_any});
            // directed checkpoints
            if (ci < chk_q.size() && chk_q[ci].cyc == cyc) begin
                chk("tbl_level",   {lvl_b, lvl_a},   {chk_q[ci].b_lvl, chk_q[ci].lvl});
                chk("tbl_press",   {prs_b, prs_a},   {chk_q[ci].b_prs, chk_q[ci].prs});
                chk("tbl_release", {1'b0, rel_a},    {1'b0, chk_q[ci].rel});
                chk("tbl_long",    {lng_b, lng_a},   {chk_q[ci].b_lng, chk_q[ci].lng});
                chk("tbl_any",     {4'b0000, any_a}, {4'b0000, chk_q[ci].any});
                ci++;
            end
            // drive inputs for this cycle
            if (cyc < DIR_END) begin
                if (di < drv_q.size() && drv_q[di].cyc == cyc) begin
                    key_a = drv_q[di].ka;
                    key_b = drv_q[di].kb;
                    rst   = drv_q[di].r;
                    di++;
                end
            end else begin
                logic [4:0] raw;
                raw = {key_b, key_a};
                for (int k = 0; k < 5; k++) begin
                    rem[k]--;
                    if (rem[k] <= 0) begin
                        raw[k] = ~raw[k];
                        rem[k] = pick_len();
                    end
                end
                key_a = raw[3:0];
                key_b = raw[4];
                rst   = ($urandom_range(0, 999) == 0) ? 1'b1 : 1'b0;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
